mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 38 +++
 rtl/mem_access_unit_lane_merge.sv | 52 +++++
 rtl/mem_access_unit.sv | 180 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared size encodings, FSM state type and index width for
//               the load/store memory access unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_unit_pkg;

    localparam int IDX_W = 5;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    // An access is aligned when its lane is a multiple of its byte count.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lane);
        case (size)
            SZ_H:    is_misaligned = lane[0];
            SZ_W:    is_misaligned = |lane[1:0];
            SZ_D:    is_misaligned = |lane;
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_lane_merge.sv
// ============================================================================
// Module      : lane_merge
// Description : Byte-lane mask, store merge and load extract/extend for one
//               little-endian doubleword.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_merge
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [2:0]  i_lane,
    input  logic        i_sign_ext,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_rdata,
    output logic [63:0] o_merged,
    output logic [63:0] o_extracted
);

    logic [7:0]  w_base_mask;
    logic [7:0]  w_byte_mask;
    logic [63:0] w_bit_mask;
    logic [63:0] w_shifted;
    logic [5:0]  w_shamt;

    always_comb begin
        w_shamt = {i_lane, 3'b000};
        case (i_size)
            SZ_B:    w_base_mask = 8'h01;
            SZ_H:    w_base_mask = 8'h03;
            SZ_W:    w_base_mask = 8'h0F;
            default: w_base_mask = 8'hFF;
        endcase
        w_byte_mask = w_base_mask << i_lane;
        w_bit_mask  = '0;
        for (int i = 0; i < 8; i++) begin
            w_bit_mask[i*8 +: 8] = {8{w_byte_mask[i]}};
        end
        o_merged  = (i_rdata & ~w_bit_mask) | ((i_wdata << w_shamt) & w_bit_mask);
        w_shifted = i_rdata >> w_shamt;
        case (i_size)
            SZ_B:    o_extracted = {{56{i_sign_ext & w_shifted[7]}},  w_shifted[7:0]};
            SZ_H:    o_extracted = {{48{i_sign_ext & w_shifted[15]}}, w_shifted[15:0]};
            SZ_W:    o_extracted = {{32{i_sign_ext & w_shifted[31]}}, w_shifted[31:0]};
            default: o_extracted = w_shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : Multi-cycle load/store unit driving a doubleword data memory,
//               with read-modify-write for sub-doubleword stores.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int IDX_W  = mem_access_unit_pkg::IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_misaligned,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    import mem_access_unit_pkg::*;

    state_t state_q, state_d;
    logic              store_q, store_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [2:0]        lane_q, lane_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_mis_q, resp_mis_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;

    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_extracted;
    logic              w_unused_addr;

    assign w_unused_addr = ^req_addr[ADDR_W-1:IDX_W+3];

    lane_merge u_lane_merge (
        .i_size      (size_q),
        .i_lane      (lane_q),
        .i_sign_ext  (sgn_q),
        .i_wdata     (wdata_q),
        .i_rdata     (mem_rdata),
        .o_merged    (w_merged),
        .o_extracted (w_extracted)
    );

    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_mis_d   = resp_mis_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    store_d    = req_store;
                    size_d     = req_size;
                    sgn_d      = req_signed;
                    lane_d     = req_addr[2:0];
                    wdata_d    = req_wdata;
                    // Only the decoded index bits reach memory, so addresses wrap.
                    mem_addr_d = {{(ADDR_W-IDX_W){1'b0}}, req_addr[IDX_W+2:3]};
                    if (is_misaligned(req_size, req_addr[2:0])) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_mis_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (req_store && (req_size == SZ_D)) begin
                        state_d     = ST_WR;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD:   state_d = ST_CAP;
            ST_CAP: begin
                if (store_q) begin
                    state_d     = ST_WR;
                    mem_wdata_d = w_merged;
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_mis_d   = 1'b0;
                    resp_rdata_d = w_extracted;
                end
            end
            ST_WR: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_mis_d   = 1'b0;
                resp_rdata_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes follow the next state so each one is a registered output.
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        mem_read_d  = (state_d == ST_RD);
        mem_write_d = (state_d == ST_WR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            store_q      <= 1'b0;
            size_q       <= SZ_B;
            sgn_q        <= 1'b0;
            lane_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_mis_q   <= 1'b0;
            busy_q       <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            store_q      <= store_d;
            size_q       <= size_d;
            sgn_q        <= sgn_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_mis_q   <= resp_mis_d;
            busy_q       <= busy_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_misaligned = resp_mis_q;
    assign busy            = busy_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench for mem_access_unit with a 32-entry memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_misaligned;
    logic        busy;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_rdata;

    typedef struct {
        logic [63:0] rdata;
        logic        mis;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mem [32];
    logic [63:0] ref_mem [32];
    logic        preload;
    int          n_tests, n_fail;
    int          cyc, acc_cyc;
    int          n_reads, n_writes, exp_reads, exp_writes;
    logic        prev_rd;
    logic [63:0] last_rdata;

    mem_access_unit #(.ADDR_W(64), .DATA_W(64), .IDX_W(5)) u_dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_store       (req_store),
        .req_size        (req_size),
        .req_signed      (req_signed),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .busy            (busy),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory: registered read on the strobe, write on the rising edge.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 64'h0;
            mem[0] <= 64'h0000_0000_8000_0000;
            mem[1] <= 64'h0123_4567_89AB_CDEF;
            mem[3] <= 64'h1122_3344_5566_7788;
        end else begin
            if (mem_write) mem[mem_addr[4:0]] <= mem_wdata;
            if (mem_read)  mem_rdata <= mem[mem_addr[4:0]];
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && req_valid && req_ready) acc_cyc <= cyc + 1;
    end

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mem_read && !prev_rd) n_reads++;
        prev_rd = mem_read;
        if (mem_write) n_writes++;
        if (!reset && resp_valid) begin
            if (sb.size() == 0) begin
                chk_val("spurious_resp", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk_val("resp_rdata", resp_rdata, e.rdata);
                chk_val("resp_misaligned", 64'(resp_misaligned), 64'(e.mis));
                chk_val("resp_latency", 64'(cyc - acc_cyc + 1), 64'(e.lat));
                last_rdata = e.rdata;
            end
        end
    end

    function automatic logic [63:0] model_load(logic [63:0] dw, int lane, int n, bit sg);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i*8 +: 8] = dw[(lane+i)*8 +: 8];
        if (sg && v[n*8-1]) for (int b = n*8; b < 64; b++) v[b] = 1'b1;
        return v;
    endfunction

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic issue(input bit st, input logic [1:0] sz, input bit sg,
                         input logic [63:0] addr, input logic [63:0] wd, input bit live);
        exp_t e;
        int   n, lane, idx, to;
        to = 0;
        while (!req_ready && to < 50) begin
            @(negedge clk);
            to++;
        end
        if (to >= 50) chk_val("ready_timeout", 64'd0, 64'd1);
        n    = 1 << sz;
        lane = int'(addr[2:0]);
        idx  = int'(addr[7:3]);
        e.mis   = (lane % n) != 0;
        e.rdata = '0;
        if (e.mis) begin
            e.lat = 1;
        end else if (!st) begin
            e.lat = 3;
            e.rdata = model_load(ref_mem[idx], lane, n, sg);
            exp_reads++;
        end else begin
            e.lat = (sz == 2'b11) ? 2 : 4;
            if (live) begin
                if (sz != 2'b11) exp_reads++;
                exp_writes++;
                for (int i = 0; i < n; i++) ref_mem[idx][(lane+i)*8 +: 8] = wd[i*8 +: 8];
            end
        end
        if (live) sb.push_back(e);
        req_valid  = 1'b1;
        req_store  = st;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int to;
        to = 0;
        while (sb.size() != 0 && to < 100) begin
            @(negedge clk);
            to++;
        end
        if (to >= 100) chk_val("drain_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          r0, w0, mism;
        logic [63:0] a;
        logic [2:0]  am;
        logic [1:0]  sz;
        clk = 0; cyc = 0; acc_cyc = 0; prev_rd = 0;
        n_tests = 0; n_fail = 0; n_reads = 0; n_writes = 0; exp_reads = 0; exp_writes = 0;
        reset = 1; preload = 1;
        // A request during reset must be ignored.
        req_valid = 1; req_store = 1; req_size = 2'b11; req_signed = 0;
        req_addr = 64'h18; req_wdata = '1;
        for (int i = 0; i < 32; i++) ref_mem[i] = 64'h0;
        ref_mem[0] = 64'h0000_0000_8000_0000;
        ref_mem[1] = 64'h0123_4567_89AB_CDEF;
        ref_mem[3] = 64'h1122_3344_5566_7788;
        repeat (3) @(negedge clk);
        chk_val("rst_req_ready", 64'(req_ready), 64'd1);
        chk_val("rst_busy", 64'(busy), 64'd0);
        chk_val("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk_val("rst_resp_mis", 64'(resp_misaligned), 64'd0);
        chk_val("rst_mem_rd_wr", {62'd0, mem_read, mem_write}, 64'd0);
        chk_val("rst_resp_rdata", resp_rdata, 64'd0);
        chk_val("rst_mem_addr", mem_addr, 64'd0);
        chk_val("rst_mem_wdata", mem_wdata, 64'd0);
        req_valid = 0; preload = 0; reset = 0;
        @(negedge clk);
        chk_val("post_rst_busy", 64'(busy), 64'd0);

        issue(0, 2'b11, 0, 64'h18, 64'h0, 1);
        drain();
        w0 = n_writes;
        issue(1, 2'b00, 0, 64'h1A, 64'hAB, 1);
        drain();
        chk_val("stb_write_pulses", 64'(n_writes - w0), 64'd1);
        chk_val("stb_dword3", mem[3], 64'h1122_3344_55AB_7788);
        issue(0, 2'b10, 1, 64'h0, 64'h0, 1);
        issue(0, 2'b10, 0, 64'h0, 64'h0, 1);
        drain();
        repeat (2) @(negedge clk);
        chk_val("resp_rdata_held", resp_rdata, last_rdata);

        r0 = n_reads; w0 = n_writes;
        issue(0, 2'b01, 0, 64'h03, 64'h0, 1);
        drain();
        chk_val("mis_no_strobes", 64'((n_reads - r0) + (n_writes - w0)), 64'd0);

        // Reset lands on the edge that ends CAP of a half-word store.
        w0 = n_writes;
        issue(1, 2'b01, 0, 64'h0C, 64'h7777, 0);
        exp_reads++;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk_val("abort_req_ready", 64'(req_ready), 64'd1);
        chk_val("abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk_val("abort_no_write", 64'(n_writes - w0), 64'd0);
        chk_val("abort_mem1", mem[1], ref_mem[1]);

        r0 = n_reads;
        issue(0, 2'b11, 0, 64'h00, 64'h0, 1);
        issue(0, 2'b11, 0, 64'h08, 64'h0, 1);
        drain();
        chk_val("b2b_read_edges", 64'(n_reads - r0), 64'd2);

        issue(0, 2'b11, 0, 64'hFFFF_0000_0000_0118, 64'h0, 1);
        for (int k = 0; k < 24; k++) begin
            a  = {$urandom, $urandom};
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                am = 3'((1 << sz) - 1);
                a[2:0] = a[2:0] & ~am;
            end
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                  {$urandom, $urandom}, 1);
        end
        drain();
        repeat (2) @(negedge clk);

        mism = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk_val("final_mem_image", 64'(mism), 64'd0);
        chk_val("total_reads", 64'(n_reads), 64'(exp_reads));
        chk_val("total_writes", 64'(n_writes), 64'(exp_writes));
        chk_val("final_idle", 64'(req_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
